// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and helpers for the uart_rx_fifo receiver.
package uart_rx_fifo_pkg;

  localparam int unsigned DATA_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } rx_state_e;

  // Frame format captured when a start bit is detected.
  typedef struct packed {
    logic [1:0] length;
    logic       stop2;
    logic       parity;
    logic       odd;
  } rx_cfg_t;

  function automatic logic parity_bad(input logic [DATA_W-1:0] data,
                                      input logic              pbit,
                                      input logic              odd);
    return ((^data) ^ pbit) != odd;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_fifo.sv
// Synchronous show-ahead FIFO: the head word is always presented on o_rdata.
module uart_rx_fifo_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LVL_W-1:0] o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW-1:0]    fill;
  logic             do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign fill    = wr_q - rd_q;
  assign o_full  = (fill == PW'(DEPTH));
  assign o_empty = (fill == '0);
  assign o_level = LVL_W'(fill);
  assign o_rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = i_pop & ~o_empty;
    do_push = i_push & (~o_full | do_pop);
    if (do_push) begin
      mem_d[wr_q[AW-1:0]] = i_wdata;
      wr_d = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit detection, error/break
// flags and an integrated show-ahead receive FIFO.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ce,
  input  logic              i_rst_err,
  input  logic [1:0]        i_length,
  input  logic              i_stop2,
  input  logic              i_parity,
  input  logic              i_odd,
  input  logic              i_rx,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_busy,
  output logic              o_overrun_err,
  output logic              o_parity_err,
  output logic              o_frame_err,
  output logic              o_break
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] TICK_S0   = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_S1   = TICK_W'(OVERSAMPLE / 2);
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic              sync1_q, sync1_d, sync2_q, sync2_d;
  rx_state_e         state_q, state_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        bit_q, bit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pbit_q, pbit_d;
  logic              s0_q, s0_d, s1_q, s1_d;
  rx_cfg_t           cfg_q, cfg_d;
  logic              brk_wait_q, brk_wait_d;
  logic              push_q, push_d;
  logic              perr_q, perr_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              break_q, break_d;

  logic              rx_s, vote, at_mid, end_bit;
  logic [3:0]        last_bit;
  logic              set_frame, set_break;
  logic              fifo_full, fifo_empty;

  assign rx_s     = sync2_q;
  assign vote     = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign at_mid   = (tick_q == TICK_MID);
  assign end_bit  = (tick_q == TICK_LAST);
  assign last_bit = 4'd5 + {2'b00, cfg_q.length};

  always_comb begin
    sync1_d    = i_rx;
    sync2_d    = sync1_q;
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    data_d     = data_q;
    pbit_d     = pbit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    cfg_d      = cfg_q;
    brk_wait_d = brk_wait_q;
    push_d     = 1'b0;
    set_frame  = 1'b0;
    set_break  = 1'b0;

    if (i_ce) begin
      if (state_q != ST_IDLE) begin
        tick_d = end_bit ? '0 : tick_q + TICK_W'(1);
      end
      if (tick_q == TICK_S0) s0_d = rx_s;
      if (tick_q == TICK_S1) s1_d = rx_s;

      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            state_d    = ST_START;
            tick_d     = '0;
            bit_d      = '0;
            data_d     = '0;
            pbit_d     = 1'b0;
            brk_wait_d = 1'b0;
            cfg_d      = '{length: i_length, stop2: i_stop2, parity: i_parity, odd: i_odd};
          end
        end
        ST_START: begin
          if (at_mid && vote) state_d = ST_IDLE;
          else if (end_bit)   state_d = ST_DATA;
        end
        ST_DATA: begin
          if (at_mid) data_d[bit_q] = vote;
          if (end_bit) begin
            if (bit_q == last_bit) state_d = cfg_q.parity ? ST_PARITY : ST_STOP1;
            else                   bit_d   = bit_q + 4'd1;
          end
        end
        ST_PARITY: begin
          if (at_mid)  pbit_d  = vote;
          if (end_bit) state_d = ST_STOP1;
        end
        ST_STOP1: begin
          // After a break the receiver parks here until the line idles high.
          if (brk_wait_q) begin
            if (rx_s) state_d = ST_IDLE;
          end else if (at_mid) begin
            if (!vote && (data_q == '0) && !pbit_q) begin
              set_break  = 1'b1;
              brk_wait_d = 1'b1;
            end else if (!vote) begin
              set_frame = 1'b1;
              state_d   = ST_IDLE;
            end else if (!cfg_q.stop2) begin
              push_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (end_bit) begin
            state_d = ST_STOP2;
          end
        end
        ST_STOP2: begin
          if (at_mid) begin
            if (!vote) set_frame = 1'b1;
            else       push_d    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Parity error is flagged on the same edge the word enters the FIFO.
    perr_d       = push_d & cfg_q.parity & parity_bad(data_q, pbit_q, cfg_q.odd);
    busy_d       = (state_d != ST_IDLE);
    overrun_d    = (push_q & fifo_full & ~i_rd) | (overrun_q & ~i_rst_err);
    parity_err_d = perr_q | (parity_err_q & ~i_rst_err);
    frame_err_d  = set_frame | (frame_err_q & ~i_rst_err);
    break_d      = set_break | (break_q & ~i_rst_err);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      state_q      <= ST_IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      data_q       <= '0;
      pbit_q       <= 1'b0;
      s0_q         <= 1'b1;
      s1_q         <= 1'b1;
      cfg_q        <= '0;
      brk_wait_q   <= 1'b0;
      push_q       <= 1'b0;
      perr_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      data_q       <= data_d;
      pbit_q       <= pbit_d;
      s0_q         <= s0_d;
      s1_q         <= s1_d;
      cfg_q        <= cfg_d;
      brk_wait_q   <= brk_wait_d;
      push_q       <= push_d;
      perr_q       <= perr_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      break_q      <= break_d;
    end
  end

  uart_rx_fifo_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push_q),
    .i_wdata (data_q),
    .i_pop   (i_rd),
    .o_rdata (o_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign o_valid       = ~fifo_empty;
  assign o_busy        = busy_q;
  assign o_overrun_err = overrun_q;
  assign o_parity_err  = parity_err_q;
  assign o_frame_err   = frame_err_q;
  assign o_break       = break_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed frames plus randomized
// frames checked against a queue-based frame model.
module tb_uart_rx_fifo;

  localparam int unsigned OS    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LVL_W = 5;

  logic             i_clk = 1'b0;
  logic             i_rst_n, i_ce, i_rst_err, i_stop2, i_parity, i_odd, i_rx, i_rd;
  logic [1:0]       i_length;
  logic [8:0]       o_data;
  logic             o_valid, o_busy, o_overrun_err, o_parity_err, o_frame_err, o_break;
  logic [LVL_W-1:0] o_level;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: queued words and sticky flags.
  logic [8:0] m_q[$];
  logic       m_ovr, m_par, m_frm, m_brk;

  uart_rx_fifo #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_ce(i_ce), .i_rst_err(i_rst_err),
    .i_length(i_length), .i_stop2(i_stop2), .i_parity(i_parity), .i_odd(i_odd),
    .i_rx(i_rx), .i_rd(i_rd), .o_data(o_data), .o_valid(o_valid), .o_level(o_level),
    .o_busy(o_busy), .o_overrun_err(o_overrun_err), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_break(o_break)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic send_bit(input logic b);
    i_rx = b;
    repeat (OS) step();
  endtask

  // One-clock inverted glitch well inside the bit.
  task automatic glitch_bit(input logic b);
    i_rx = b;
    repeat (9) step();
    i_rx = ~b;
    step();
    i_rx = b;
    repeat (OS - 10) step();
  endtask

  task automatic set_cfg(input int nbits, input logic par, input logic odd, input logic stop2);
    i_length = 2'(nbits - 6);
    i_parity = par;
    i_odd    = odd;
    i_stop2  = stop2;
  endtask

  task automatic send_frame(input logic [8:0] data, input int nbits, input logic par,
                            input logic pbit, input logic stop_a, input logic stop2,
                            input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(data[i]);
    if (par) send_bit(pbit);
    send_bit(stop_a);
    if (stop2) send_bit(stop_b);
    send_bit(1'b1);
  endtask

  function automatic logic good_pbit(input logic [8:0] data, input logic odd);
    return (($countones(data) % 2) == 0) ? odd : ~odd;
  endfunction

  task automatic pop();
    i_rd = 1'b1;
    step();
    i_rd = 1'b0;
  endtask

  task automatic pulse_rst_err();
    i_rst_err = 1'b1;
    step();
    i_rst_err = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, 32'({o_overrun_err, o_parity_err, o_frame_err, o_break}), 32'(exp));
  endtask

  task automatic check_model(input string tag);
    check({tag, "_lvl"}, 32'(o_level), 32'(m_q.size()));
    check_flags({tag, "_flags"}, {m_ovr, m_par, m_frm, m_brk});
    if (m_q.size() > 0) check({tag, "_head"}, 32'(o_data), 32'(m_q[0]));
  endtask

  initial begin
    logic       seen;
    logic [3:0] lvl0;
    logic [8:0] d;
    i_rst_n = 1'b0; i_ce = 1'b1; i_rst_err = 1'b0; i_rx = 1'b1; i_rd = 1'b0;
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    idle(2);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_level", 32'(o_level), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    check("rst_busy",  32'(o_busy),  32'd0);
    check_flags("rst_flags", 4'b0000);
    i_rst_n = 1'b1;
    idle(20);

    // 9-bit, odd parity, two stop bits, good parity.
    set_cfg(9, 1'b1, 1'b1, 1'b1);
    send_frame(9'h155, 9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    check("f9_data",  32'(o_data),  32'h155);
    check("f9_valid", 32'(o_valid), 32'd1);
    check("f9_level", 32'(o_level), 32'd1);
    check_flags("f9_flags", 4'b0000);
    pop();
    check("f9_pop_valid", 32'(o_valid), 32'd0);

    // Same frame, bad parity bit: still pushed, flag set.
    send_frame(9'h155, 9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("perr_data",  32'(o_data),  32'h155);
    check("perr_level", 32'(o_level), 32'd1);
    check_flags("perr_flags", 4'b0100);
    pulse_rst_err();
    check_flags("perr_clr", 4'b0000);
    pop();

    // Clear request held through the push edge: set must win.
    seen = 1'b0;
    lvl0 = 4'(o_level);
    fork
      send_frame(9'h155, 9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      begin
        i_rst_err = 1'b1;
        for (int k = 0; k < 400; k++) begin
          step();
          if (4'(o_level) != lvl0) begin
            seen = 1'b1;
            break;
          end
        end
        i_rst_err = 1'b0;
        check("perr_race_push", 32'(seen), 32'd1);
        check("perr_race_set",  32'(o_parity_err), 32'd1);
      end
    join
    check("perr_race_sticky", 32'(o_parity_err), 32'd1);
    pop();
    pulse_rst_err();

    // False start: short low pulse.
    set_cfg(8, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    i_rx = 1'b0;
    repeat (4) begin step(); seen |= o_busy; end
    i_rx = 1'b1;
    repeat (40) begin step(); seen |= o_busy; end
    check("fstart_busy_seen", 32'(seen),    32'd1);
    check("fstart_idle",      32'(o_busy),  32'd0);
    check("fstart_level",     32'(o_level), 32'd0);

    // Single-clock glitches inside data bits are voted out.
    d = 9'h069;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 2 || i == 5) glitch_bit(d[i]);
      else send_bit(d[i]);
    end
    send_bit(1'b1);
    send_bit(1'b1);
    check("glitch_data",  32'(o_data),  32'h069);
    check("glitch_level", 32'(o_level), 32'd1);
    check_flags("glitch_flags", 4'b0000);
    pop();

    // Fill past capacity.
    for (int f = 0; f < 17; f++) send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("full_level", 32'(o_level), 32'd16);
    check("full_data",  32'(o_data),  32'h0A5);
    check_flags("full_flags", 4'b1000);
    pulse_rst_err();
    check_flags("full_clr", 4'b0000);

    // Pop on the exact push edge while full.
    fork
      send_frame(9'h05A, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      begin
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin step(); seen = o_busy; end
        for (int k = 0; k < 400 && seen; k++) begin step(); seen = o_busy; end
        check("full_rdw_busy_fall", 32'(seen), 32'd0);
        pop();
      end
    join
    check("full_rdw_level", 32'(o_level), 32'd16);
    check_flags("full_rdw_flags", 4'b0000);
    for (int i = 0; i < 15; i++) begin
      check("drain_a5", 32'(o_data), 32'h0A5);
      pop();
    end
    check("drain_tail", 32'(o_data), 32'h05A);
    pop();
    check("drain_empty", 32'(o_valid), 32'd0);

    // Stop bit low: frame error, nothing pushed.
    send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(16);
    check("ferr_level", 32'(o_level), 32'd0);
    check_flags("ferr_flags", 4'b0010);
    pulse_rst_err();

    // Break: line low for 12 bit times.
    i_rx = 1'b0;
    repeat (12 * OS) step();
    check_flags("brk_flags", 4'b0001);
    check("brk_level", 32'(o_level), 32'd0);
    i_rx = 1'b1;
    idle(2 * OS);
    check("brk_idle", 32'(o_busy), 32'd0);
    send_frame(9'h03C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("brk_next_data",  32'(o_data),  32'h03C);
    check("brk_next_level", 32'(o_level), 32'd1);
    check_flags("brk_next_flags", 4'b0001);

    // Reset in the middle of the data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    i_rst_n = 1'b0;
    step();
    check("mrst_busy",  32'(o_busy),  32'd0);
    check("mrst_level", 32'(o_level), 32'd0);
    check("mrst_valid", 32'(o_valid), 32'd0);
    check_flags("mrst_flags", 4'b0000);
    i_rst_n = 1'b1;
    i_rx = 1'b1;
    idle(3 * OS);
    send_frame(9'h096, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("mrst_next_data",  32'(o_data),  32'h096);
    check("mrst_next_level", 32'(o_level), 32'd1);
    check_flags("mrst_next_flags", 4'b0000);

    // Randomized frames against the model.
    i_rst_n = 1'b0;
    idle(2);
    i_rst_n = 1'b1;
    m_q.delete();
    m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_brk = 1'b0;
    idle(OS);
    for (int it = 0; it < 40; it++) begin
      int         nbits, kind, npop;
      logic       par, odd, stop2, pbit, stop_a, stop_b, perr;
      logic [8:0] mask;
      nbits  = 6 + int'($urandom_range(0, 3));
      par    = 1'($urandom_range(0, 1));
      odd    = 1'($urandom_range(0, 1));
      stop2  = 1'($urandom_range(0, 1));
      mask   = 9'((1 << nbits) - 1);
      d      = 9'($urandom) & mask;
      if ($urandom_range(0, 7) == 0) d = '0;
      pbit   = par ? good_pbit(d, odd) : 1'b0;
      kind   = int'($urandom_range(0, 9));
      stop_a = (kind != 0);
      stop_b = !(kind == 1 && stop2);
      if (par && stop_a && stop_b && $urandom_range(0, 3) == 0) pbit = ~pbit;

      set_cfg(nbits, par, odd, stop2);
      send_frame(d, nbits, par, pbit, stop_a, stop2, stop_b);
      idle(4);

      if (!stop_a) begin
        if (d == '0 && !pbit) m_brk = 1'b1;
        else                  m_frm = 1'b1;
      end else if (!stop_b) begin
        m_frm = 1'b1;
      end else begin
        perr = par && ((($countones(d) + int'(pbit)) % 2) != int'(odd));
        if (perr) m_par = 1'b1;
        if (m_q.size() < int'(DEPTH)) m_q.push_back(d);
        else                          m_ovr = 1'b1;
      end
      check_model("rnd");

      npop = ($urandom_range(0, 3) == 0) ? 2 : 0;
      for (int p = 0; p < npop; p++) begin
        pop();
        if (m_q.size() > 0) void'(m_q.pop_front());
      end
      if ($urandom_range(0, 5) == 0) begin
        pulse_rst_err();
        m_ovr = 1'b0; m_par = 1'b0; m_frm = 1'b0; m_brk = 1'b0;
      end
      check_model("rnd_post");
    end
    while (m_q.size() > 0) begin
      check("rnd_drain", 32'(o_data), 32'(m_q[0]));
      pop();
      void'(m_q.pop_front());
    end
    check("rnd_drain_empty", 32'(o_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised successor to uart_rx: an asynchronous serial receiver with configurable oversampling and 3-sample majority-vote bit detection.
- Adds framing-error and break detection, plus an integrated show-ahead receive FIFO.
- Sits between the pad-side RX line and the UART register interface. The bus side pops words with a one-cycle read strobe.

Parameters:
OVERSAMPLE, 16, i_ce ticks per bit; even, >= 8
FIFO_DEPTH, 16, receive FIFO entries; power of two, >= 2
LVL_W, $clog2(FIFO_DEPTH)+1, width of o_level

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  synchronous active-low reset
i_ce  in  1  oversample tick; all RX sampling logic advances only when high
i_rst_err  in  1  one-cycle pulse that clears all sticky error flags
i_length  in  2  data bits = 6 + i_length (6..9)
i_stop2  in  1  two stop bits
i_parity  in  1  parity bit present
i_odd  in  1  odd parity (else even)
i_rx  in  1  asynchronous serial input, idle high
i_rd  in  1  pop FIFO head
o_data  out  9  FIFO head, LSB-aligned, zero-extended
o_valid  out  1  FIFO not empty
o_level  out  LVL_W  FIFO occupancy
o_busy  out  1  receiver not IDLE
o_overrun_err  out  1  sticky: word dropped because FIFO was full
o_parity_err  out  1  sticky: parity mismatch
o_frame_err  out  1  sticky: stop bit sampled low
o_break  out  1  sticky: break frame received

Behaviour:
- Reset (i_rst_n=0 at an i_clk edge): state IDLE; counters 0; synchroniser flops 1; FIFO emptied.
  - All outputs 0: o_valid, o_level, o_data, o_busy and every error flag.
  - Reset mid-frame abandons the frame; no push occurs.
- Synchroniser: i_rx passes through 2 flops on every clock, independent of i_ce.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - Tick counter runs 0..OVERSAMPLE-1 per bit; bit counter tracks DATA bits.
- Majority vote: at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, bit value = 2-of-3 vote.
  - The bit decision is taken at tick OVERSAMPLE/2+1.
- IDLE: synchronised low seen on an i_ce tick -> START, counter 0.
  - i_length, i_stop2, i_parity and i_odd are latched on this tick.
  - Config changes mid-frame have no effect until the next frame.
- START: voted 1 -> false start, back to IDLE, nothing recorded. Voted 0 -> DATA after the full bit.
- DATA: bits shift in LSB first. After 6+len bits -> PARITY if parity is enabled, else STOP1.
- PARITY: error when XOR(data bits, parity bit) != i_odd.
- STOP1: decision at mid-bit.
  - Break frame = all data bits 0, parity bit 0 (if present), stop 0. Sets o_break; no push; o_frame_err is not set. Receiver waits in STOP1 until the line is 1, then -> IDLE.
  - Otherwise stop = 0 -> set o_frame_err, discard the word, -> IDLE.
  - Otherwise, if i_stop2 -> STOP2 at end of bit, else push word and -> IDLE immediately at mid-bit (half-bit resync margin).
- STOP2: voted 0 -> o_frame_err set, word discarded. Otherwise push. -> IDLE at mid-bit.
- Parity-error words are still pushed; o_parity_err is set in the same cycle.
- Push happens on the clock edge after the final stop-bit decision. o_valid and o_level update on that edge.
- FIFO is show-ahead: o_data is always the head.
  - i_rd while empty is ignored.
  - Push while full with no i_rd: word dropped, o_overrun_err set, contents unchanged.
  - Push and pop in the same cycle (including when full): both happen, level unchanged, no overrun.
- Sticky flags: if set and i_rst_err occur in the same cycle, set wins.
- i_ce low: the receiver freezes. FIFO pop and i_rst_err still act.

Decomposition:
- uart_defs.vh: state encodings, parity helper function, data width constant (9).
- Sub-module uart_fifo: synchronous show-ahead FIFO (DEPTH, WIDTH parameters; push/pop/full/empty/level).

Test Plan:
All cases use OVERSAMPLE=16, i_ce=1 (16 clocks per bit), default FIFO_DEPTH.
- 9-bit frame, odd parity, 2 stop bits, data bits 1,0,1,0,1,0,1,0,1, parity 0 -> o_data=9'h155, o_valid=1, o_level=1, no errors; i_rd -> o_valid=0.
- Same frame with parity bit 1 -> word 9'h155 pushed, o_parity_err=1; i_rst_err pulse -> 0. Assert i_rst_err and a new parity error in the same cycle -> flag stays 1.
- rx low for 4 clocks then high -> o_busy pulses, returns to IDLE, o_level stays 0. A single-clock high glitch inside a data bit -> word unaffected (vote).
- 17 frames of 8'hA5 (8-bit, no parity), no reads -> o_level=16, o_overrun_err=1, head=8'hA5. Simultaneous i_rd and push at full -> o_level stays 16, no new overrun.
- 8-bit frame with stop bit 0 -> o_frame_err=1, no push. rx low for 12 bit times -> o_break=1, o_frame_err unchanged; after line high, a normal frame 8'h3C is received correctly.
- i_rst_n low mid-DATA -> o_busy=0, FIFO empty, all flags 0 next cycle; the next full frame decodes normally.
